// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide TX FIFO feeding an 8N1 / 8E1 UART serialiser.
// The FIFO uses extended (MSB-tagged) pointers so full and empty are told
// apart without a separate count; the serialiser is a two-process FSM whose
// output bit, level, ready and busy flags are all registered.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int PARITY_EN  = 0,
    parameter int DIV_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [DIV_W-1:0]              clk_div_i,
    input  logic                          tx_en_i,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]      PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]      FULL_LVL = (AW+1)'(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    // FIFO storage and pointers
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_r, rd_ptr_r;
    logic [AW:0]      wr_nxt_s, rd_nxt_s, lvl_nxt_s;
    logic             full_s, empty_s, push_s, pop_s, launch_s;
    logic [7:0]       head_s;

    // Serialiser state
    state_t           state_r, state_s;
    logic [DIV_W-1:0] baud_r, baud_s;
    logic [DIV_W-1:0] div_r, div_s;
    logic [2:0]       bit_r, bit_s;
    logic [7:0]       shift_r, shift_s;
    logic             par_r, par_s;
    logic             tx_r, tx_s;
    logic             expire_s;

    // Registered status outputs
    logic             ready_r, busy_r;
    logic [AW:0]      level_r;

    assign full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty_s  = (wr_ptr_r == rd_ptr_r);
    assign push_s   = valid_i && !full_s;
    assign launch_s = !empty_s && tx_en_i;
    assign head_s   = mem_r[rd_ptr_r[AW-1:0]];
    assign expire_s = (baud_r == (div_r - DIV_ONE));

    // Next-state and next-output logic of the serialiser; a frame launch
    // (from IDLE or straight out of STOP) pops the head byte and latches the divisor.
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        div_s   = div_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        par_s   = par_r;
        tx_s    = tx_r;
        pop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    state_s = ST_START;
                    pop_s   = 1'b1;
                    shift_s = head_s;
                    par_s   = even_parity(head_s);
                    div_s   = (clk_div_i == DIV_ZERO) ? DIV_ONE : clk_div_i;
                    baud_s  = DIV_ZERO;
                    bit_s   = 3'd0;
                    tx_s    = 1'b0;
                end else begin
                    tx_s    = 1'b1;
                end
            end
            ST_START: begin
                if (expire_s) begin
                    state_s = ST_DATA;
                    baud_s  = DIV_ZERO;
                    bit_s   = 3'd0;
                    tx_s    = shift_r[0];
                end else begin
                    baud_s  = baud_r + DIV_ONE;
                end
            end
            ST_DATA: begin
                if (expire_s) begin
                    baud_s = DIV_ZERO;
                    if (bit_r == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_s = ST_PARITY;
                            tx_s    = par_r;
                        end else begin
                            state_s = ST_STOP;
                            tx_s    = 1'b1;
                        end
                    end else begin
                        bit_s   = bit_r + 3'd1;
                        shift_s = {1'b0, shift_r[7:1]};
                        tx_s    = shift_r[1];
                    end
                end else begin
                    baud_s = baud_r + DIV_ONE;
                end
            end
            ST_PARITY: begin
                if (expire_s) begin
                    state_s = ST_STOP;
                    baud_s  = DIV_ZERO;
                    tx_s    = 1'b1;
                end else begin
                    baud_s  = baud_r + DIV_ONE;
                end
            end
            ST_STOP: begin
                if (expire_s) begin
                    baud_s = DIV_ZERO;
                    if (launch_s) begin
                        state_s = ST_START;
                        pop_s   = 1'b1;
                        shift_s = head_s;
                        par_s   = even_parity(head_s);
                        div_s   = (clk_div_i == DIV_ZERO) ? DIV_ONE : clk_div_i;
                        bit_s   = 3'd0;
                        tx_s    = 1'b0;
                    end else begin
                        state_s = ST_IDLE;
                        tx_s    = 1'b1;
                    end
                end else begin
                    baud_s = baud_r + DIV_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                baud_s  = DIV_ZERO;
                tx_s    = 1'b1;
            end
        endcase
    end

    // Next pointer values, used both for the pointers and the registered flags.
    always_comb begin
        wr_nxt_s = wr_ptr_r;
        rd_nxt_s = rd_ptr_r;
        if (push_s) begin
            wr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_nxt_s = rd_ptr_r;
        end
        lvl_nxt_s = wr_nxt_s - rd_nxt_s;
    end

    // FIFO storage write; contents are only ever read while the entry is valid.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= data_i;
        end
    end

    // State, pointer and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            baud_r   <= DIV_ZERO;
            div_r    <= DIV_ONE;
            bit_r    <= 3'd0;
            shift_r  <= 8'd0;
            par_r    <= 1'b0;
            tx_r     <= 1'b1;
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            level_r  <= {(AW+1){1'b0}};
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            baud_r   <= baud_s;
            div_r    <= div_s;
            bit_r    <= bit_s;
            shift_r  <= shift_s;
            par_r    <= par_s;
            tx_r     <= tx_s;
            wr_ptr_r <= wr_nxt_s;
            rd_ptr_r <= rd_nxt_s;
            level_r  <= lvl_nxt_s;
            ready_r  <= (lvl_nxt_s != FULL_LVL);
            busy_r   <= (state_s != ST_IDLE) || (lvl_nxt_s != {(AW+1){1'b0}});
        end
    end

    assign tx_o         = tx_r;
    assign ready_o      = ready_r;
    assign busy_o       = busy_r;
    assign fifo_level_o = level_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: drives an 8N1 instance and an 8E1 instance with the same
// stimulus and compares every cycle against a frame-level reference model
// (byte queue + list of frame bits, each held for the latched period).
module tb_uart_tx_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, tx_en, valid;
    logic [15:0] clk_div;
    logic [7:0]  data;
    logic        ready0, tx0, busy0, ready1, tx1, busy1;
    logic [3:0]  level0, level1;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // reference model state, index 0 = 8N1, 1 = 8E1
    int          mcnt  [2] = '{0, 0};
    int          mhead [2] = '{0, 0};
    logic [7:0]  mbuf  [2][DEPTH];
    bit          mact  [2] = '{1'b0, 1'b0};
    logic [10:0] mbits [2];
    int          mn [2], midx [2], mtick [2], mper [2];
    logic        mtx   [2] = '{1'b1, 1'b1};

    uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .PARITY_EN(0), .DIV_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .clk_div_i(clk_div), .tx_en_i(tx_en),
        .data_i(data), .valid_i(valid), .ready_o(ready0), .tx_o(tx0),
        .busy_o(busy0), .fifo_level_o(level0));

    uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .PARITY_EN(1), .DIV_W(16)) dut_p (
        .clk_i(clk), .rst_i(rst), .clk_div_i(clk_div), .tx_en_i(tx_en),
        .data_i(data), .valid_i(valid), .ready_o(ready1), .tx_o(tx1),
        .busy_o(busy1), .fifo_level_o(level1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // One clock of the reference: finish/advance the current frame, start the
    // next one if allowed, then accept a push if the queue was not full.
    task automatic model_step(input int p);
        bit         push;
        logic [7:0] b;
        if (rst) begin
            mcnt[p] = 0; mhead[p] = 0; mact[p] = 1'b0; mtx[p] = 1'b1;
        end else begin
            push = valid && (mcnt[p] < DEPTH);
            if (mact[p]) begin
                mtick[p]++;
                if (mtick[p] == mper[p]) begin
                    mtick[p] = 0;
                    midx[p]++;
                    if (midx[p] == mn[p]) mact[p] = 1'b0;
                end
            end
            if (!mact[p] && mcnt[p] > 0 && tx_en) begin
                b = mbuf[p][mhead[p]];
                mhead[p] = (mhead[p] + 1) % DEPTH;
                mcnt[p]--;
                if (p == 1) begin
                    mbits[p] = {1'b1, ^b, b, 1'b0};
                    mn[p] = 11;
                end else begin
                    mbits[p] = {1'b1, 1'b1, b, 1'b0};
                    mn[p] = 10;
                end
                midx[p] = 0; mtick[p] = 0;
                mper[p] = (clk_div == 16'd0) ? 1 : int'(clk_div);
                mact[p] = 1'b1;
            end
            if (push) begin
                mbuf[p][(mhead[p] + mcnt[p]) % DEPTH] = data;
                mcnt[p]++;
            end
            mtx[p] = mact[p] ? mbits[p][midx[p]] : 1'b1;
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    // continuous comparison of every output of both instances
    always @(negedge clk) begin
        if (chk_en) begin
            check("tx0",   32'(tx0),    32'(mtx[0]));
            check("rdy0",  32'(ready0), 32'(mcnt[0] < DEPTH));
            check("busy0", 32'(busy0),  32'(mact[0] || mcnt[0] != 0));
            check("lvl0",  32'(level0), 32'(mcnt[0]));
            check("tx1",   32'(tx1),    32'(mtx[1]));
            check("rdy1",  32'(ready1), 32'(mcnt[1] < DEPTH));
            check("busy1", 32'(busy1),  32'(mact[1] || mcnt[1] != 0));
            check("lvl1",  32'(level1), 32'(mcnt[1]));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push1(input logic [7:0] b);
        valid = 1'b1; data = b;
        cyc(1);
        valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; data = 8'd0; tx_en = 1'b0; clk_div = 16'd4;
        cyc(2);
        rst = 1'b0; chk_en = 1'b1;
        check("rst_tx",    32'(tx0),    32'd1);
        check("rst_ready", 32'(ready0), 32'd1);
        check("rst_busy",  32'(busy0),  32'd0);
        check("rst_level", 32'(level0), 32'd0);

        // 0x55 at div 4: latency and busy window
        tx_en = 1'b1; clk_div = 16'd4;
        push1(8'h55);
        check("lat_idle",  32'(tx0), 32'd1);
        cyc(1);
        check("lat_start", 32'(tx0), 32'd0);
        cyc(39);
        check("busy_last", 32'(busy0), 32'd1);
        cyc(1);
        check("busy_drop", 32'(busy0), 32'd0);
        cyc(5);

        // back-to-back frames at div 3
        clk_div = 16'd3;
        valid = 1'b1; data = 8'h00; cyc(1);
        data = 8'hFF; cyc(1);
        data = 8'hA5; cyc(1);
        valid = 1'b0;
        cyc(110);

        // fill with transmitter disabled, no bypass at full
        tx_en = 1'b0; clk_div = 16'd2;
        valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            data = 8'($urandom);
            cyc(1);
        end
        valid = 1'b0;
        check("full_level", 32'(level0), 32'd8);
        check("full_ready", 32'(ready0), 32'd0);
        check("full_tx",    32'(tx0),    32'd1);
        cyc(10);
        tx_en = 1'b1;
        cyc(200);

        // parity frames at div 2
        push1(8'h07);
        push1(8'h03);
        cyc(60);

        // reset during the 5th data bit with 3 bytes queued
        clk_div = 16'd4;
        valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data = 8'($urandom);
            cyc(1);
        end
        valid = 1'b0;
        cyc(18);
        check("q3_level", 32'(level0), 32'd3);
        rst = 1'b1; cyc(1); rst = 1'b0;
        check("mid_rst_tx",    32'(tx0),    32'd1);
        check("mid_rst_level", 32'(level0), 32'd0);
        check("mid_rst_busy",  32'(busy0),  32'd0);
        cyc(60);

        // divisor 0 and a divisor change mid-frame
        clk_div = 16'd0;
        push1(8'h3C);
        cyc(20);
        clk_div = 16'd4;
        push1(8'hC3);
        cyc(10);
        clk_div = 16'd8;
        push1(8'h5A);
        cyc(200);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            valid = 1'($urandom_range(0, 1));
            data  = 8'($urandom);
            tx_en = ($urandom_range(0, 9) != 0);
            rst   = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 99) < 5) clk_div = 16'($urandom_range(0, 5));
            cyc(1);
        end

        // drain with a bounded wait
        rst = 1'b0; valid = 1'b0; tx_en = 1'b1;
        begin
            int k;
            k = 0;
            while ((mact[0] || mcnt[0] != 0 || mact[1] || mcnt[1] != 0) && k < 3000) begin
                cyc(1);
                k++;
            end
            if (k >= 3000) check("drain_timeout", 32'd1, 32'd0);
        end
        cyc(2);
        check("end_busy0", 32'(busy0), 32'd0);
        check("end_busy1", 32'(busy1), 32'd0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
